// File: rtl/bullet_pool_pkg.sv
// Shared tank/bullet definitions: direction encoding, playfield bounds,
// HID keycodes and the obstacle overlap test used by both tanks and bullets.
package bullet_pool_pkg;

  typedef enum logic [2:0] {
    DIR_UP    = 3'b000,
    DIR_DOWN  = 3'b001,
    DIR_LEFT  = 3'b010,
    DIR_RIGHT = 3'b011
  } dir_t;

  localparam int NUM_OBS = 12;

  localparam logic signed [11:0] X_MIN = 12'sd0;
  localparam logic signed [11:0] X_MAX = 12'sd639;
  localparam logic signed [11:0] Y_MIN = 12'sd16;
  localparam logic signed [11:0] Y_MAX = 12'sd479;

  localparam logic [7:0] KEY_W    = 8'h1A;
  localparam logic [7:0] KEY_A    = 8'h04;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_D    = 8'h07;
  localparam logic [7:0] KEY_FIRE = 8'h2C;

  // Strict overlap: boxes that merely touch an obstacle edge do not collide.
  function automatic logic rect_overlaps_obs(
    input logic signed [11:0] l,
    input logic signed [11:0] r,
    input logic signed [11:0] t,
    input logic signed [11:0] b,
    input logic [9:0]         obs_l,
    input logic [9:0]         obs_r,
    input logic [8:0]         obs_t,
    input logic [8:0]         obs_b
  );
    return (l < $signed({2'b00, obs_r})) && (r > $signed({2'b00, obs_l})) &&
           (t < $signed({3'b000, obs_b})) && (b > $signed({3'b000, obs_t}));
  endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// Tank-side bus of the bullet pool: tank state and obstacles in, bullet table out.
interface bullet_pool_if #(
  parameter int NUM_BULLETS = 5
);
  logic [31:0]                                  keycode;
  logic [9:0]                                   TankX;
  logic [9:0]                                   TankY;
  logic [2:0]                                   TankDir;
  logic                                         shoot_en;
  logic                                         TankDead;
  logic [bullet_pool_pkg::NUM_OBS-1:0][9:0]     obs_left;
  logic [bullet_pool_pkg::NUM_OBS-1:0][9:0]     obs_right;
  logic [bullet_pool_pkg::NUM_OBS-1:0][8:0]     obs_top;
  logic [bullet_pool_pkg::NUM_OBS-1:0][8:0]     obs_bottom;
  logic [NUM_BULLETS-1:0][9:0]                  BulletX;
  logic [NUM_BULLETS-1:0][9:0]                  BulletY;
  logic [NUM_BULLETS-1:0][2:0]                  BulletDir;
  logic [NUM_BULLETS-1:0][3:0]                  BulletAge;
  logic [NUM_BULLETS-1:0]                       Is_bullet_active;
  logic                                         fire_pulse;

  modport master (
    output keycode, TankX, TankY, TankDir, shoot_en, TankDead,
    output obs_left, obs_right, obs_top, obs_bottom,
    input  BulletX, BulletY, BulletDir, BulletAge, Is_bullet_active, fire_pulse
  );

  modport slave (
    input  keycode, TankX, TankY, TankDir, shoot_en, TankDead,
    input  obs_left, obs_right, obs_top, obs_bottom,
    output BulletX, BulletY, BulletDir, BulletAge, Is_bullet_active, fire_pulse
  );
endinterface

// File: rtl/bullet_pool_slot.sv
// One bullet slot: spawn load, per-frame motion, ageing and expiry
// (age limit, playfield bound, obstacle hit).
module bullet_pool_slot
  import bullet_pool_pkg::*;
#(
  parameter int BULLET_STEP = 4,
  parameter int MAX_AGE     = 15
) (
  input  logic                        frame_clk,
  input  logic                        Reset,
  input  logic                        spawn,
  input  logic [9:0]                  spawn_x,
  input  logic [9:0]                  spawn_y,
  input  dir_t                        spawn_dir,
  input  logic [NUM_OBS-1:0][9:0]     obs_left,
  input  logic [NUM_OBS-1:0][9:0]     obs_right,
  input  logic [NUM_OBS-1:0][8:0]     obs_top,
  input  logic [NUM_OBS-1:0][8:0]     obs_bottom,
  output logic [9:0]                  x,
  output logic [9:0]                  y,
  output dir_t                        dir,
  output logic [3:0]                  age,
  output logic                        active
);

  localparam logic signed [11:0] STEP     = 12'(BULLET_STEP);
  localparam logic signed [11:0] BOX      = 12'sd2;
  localparam logic [3:0]         AGE_LAST = 4'(MAX_AGE);

  logic signed [11:0] nx_p0, ny_p0;
  logic               oob_p0, hit_p0, expire_p0;

  // Next position is computed two bits wider so a move past 0 is caught, never wrapped.
  always_comb begin
    nx_p0 = $signed({2'b00, x});
    ny_p0 = $signed({2'b00, y});
    case (dir)
      DIR_UP:    ny_p0 = ny_p0 - STEP;
      DIR_DOWN:  ny_p0 = ny_p0 + STEP;
      DIR_LEFT:  nx_p0 = nx_p0 - STEP;
      DIR_RIGHT: nx_p0 = nx_p0 + STEP;
      default:   ;
    endcase
    oob_p0 = (nx_p0 < X_MIN + BOX) || (nx_p0 > X_MAX - BOX) ||
             (ny_p0 < Y_MIN + BOX) || (ny_p0 > Y_MAX - BOX);
    hit_p0 = 1'b0;
    for (int k = 0; k < NUM_OBS; k++) begin
      if (rect_overlaps_obs(nx_p0 - BOX, nx_p0 + BOX, ny_p0 - BOX, ny_p0 + BOX,
                            obs_left[k], obs_right[k], obs_top[k], obs_bottom[k]))
        hit_p0 = 1'b1;
    end
    expire_p0 = (age == AGE_LAST) || oob_p0 || hit_p0;
  end

  // ---- frame register stage ----
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      active <= 1'b0;
      age    <= '0;
      dir    <= DIR_UP;
      x      <= '0;
      y      <= '0;
    end else if (spawn) begin
      active <= 1'b1;
      age    <= '0;
      dir    <= spawn_dir;
      x      <= spawn_x;
      y      <= spawn_y;
    end else if (active) begin
      if (expire_p0) begin
        active <= 1'b0;
      end else begin
        x   <= nx_p0[9:0];
        y   <= ny_p0[9:0];
        age <= age + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bullet_pool.sv
// Bullet manager for one tank: fire-key edge detect, cooldown, lowest-free
// slot allocation, and one bullet_pool_slot per bullet.
module bullet_pool
  import bullet_pool_pkg::*;
#(
  parameter int         NUM_BULLETS  = 5,
  parameter logic [7:0] FIRE_KEY     = KEY_FIRE,
  parameter int         BULLET_STEP  = 4,
  parameter int         SHOOT_OFFSET = 20,
  parameter int         COOLDOWN     = 8,
  parameter int         MAX_AGE      = 15
) (
  input  logic          frame_clk,
  input  logic          Reset,
  bullet_pool_if.slave  bus
);

  localparam logic [7:0] CD_LOAD = 8'(COOLDOWN - 1);
  localparam logic [9:0] OFFSET  = 10'(SHOOT_OFFSET);

  logic                         fire_now_p0, fire_req_p0, spawn_ok_p0, free_any_p0;
  logic [NUM_BULLETS-1:0]       free_sel_p0, spawn_vec_p0;
  logic [9:0]                   spawn_x_p0, spawn_y_p0;
  logic                         fire_prev, fire_pulse_q;
  logic [7:0]                   cooldown;
  logic [NUM_BULLETS-1:0]       active;
  logic [NUM_BULLETS-1:0][9:0]  slot_x, slot_y;
  logic [NUM_BULLETS-1:0][3:0]  slot_age;
  dir_t                         slot_dir [NUM_BULLETS];

  always_comb begin
    fire_now_p0 = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (bus.keycode[8*b +: 8] == FIRE_KEY) fire_now_p0 = 1'b1;
    end
    fire_req_p0 = fire_now_p0 & ~fire_prev;

    // Lowest-index slot that is inactive at the start of this frame.
    free_sel_p0 = '0;
    free_any_p0 = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!active[i] && !free_any_p0) begin
        free_sel_p0[i] = 1'b1;
        free_any_p0    = 1'b1;
      end
    end
    spawn_ok_p0  = fire_req_p0 & bus.shoot_en & ~bus.TankDead &
                   (cooldown == 8'd0) & free_any_p0;
    spawn_vec_p0 = spawn_ok_p0 ? free_sel_p0 : '0;

    spawn_x_p0 = bus.TankX;
    spawn_y_p0 = bus.TankY;
    case (dir_t'(bus.TankDir))
      DIR_UP:    spawn_y_p0 = bus.TankY - OFFSET;
      DIR_DOWN:  spawn_y_p0 = bus.TankY + OFFSET;
      DIR_LEFT:  spawn_x_p0 = bus.TankX - OFFSET;
      DIR_RIGHT: spawn_x_p0 = bus.TankX + OFFSET;
      default:   ;
    endcase
  end

  // ---- frame register stage ----
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      fire_prev    <= 1'b0;
      fire_pulse_q <= 1'b0;
      cooldown     <= '0;
    end else begin
      fire_prev    <= fire_now_p0;
      fire_pulse_q <= spawn_ok_p0;
      if (spawn_ok_p0)
        cooldown <= CD_LOAD;
      else if (cooldown != 8'd0)
        cooldown <= cooldown - 8'd1;
    end
  end

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    bullet_pool_slot #(
      .BULLET_STEP (BULLET_STEP),
      .MAX_AGE     (MAX_AGE)
    ) u_slot (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .spawn      (spawn_vec_p0[i]),
      .spawn_x    (spawn_x_p0),
      .spawn_y    (spawn_y_p0),
      .spawn_dir  (dir_t'(bus.TankDir)),
      .obs_left   (bus.obs_left),
      .obs_right  (bus.obs_right),
      .obs_top    (bus.obs_top),
      .obs_bottom (bus.obs_bottom),
      .x          (slot_x[i]),
      .y          (slot_y[i]),
      .dir        (slot_dir[i]),
      .age        (slot_age[i]),
      .active     (active[i])
    );
    assign bus.BulletDir[i] = slot_dir[i];
  end

  assign bus.BulletX          = slot_x;
  assign bus.BulletY          = slot_y;
  assign bus.BulletAge        = slot_age;
  assign bus.Is_bullet_active = active;
  assign bus.fire_pulse       = fire_pulse_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench: two pools (cooldown 8 and cooldown 1) share the same tank
// stimulus; a frame-level reference model predicts each bullet table.
module tb_bullet_pool;
  import bullet_pool_pkg::*;

  typedef struct packed {
    logic [4:0]       mask;
    logic             pulse;
    logic [4:0][9:0]  x;
    logic [4:0][9:0]  y;
    logic [4:0][2:0]  dir;
    logic [4:0][3:0]  age;
  } exp_t;

  logic frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  logic                       Reset;
  logic [31:0]                keycode;
  logic [9:0]                 tank_x, tank_y;
  logic [2:0]                 tank_dir;
  logic                       shoot_en, tank_dead;
  logic [NUM_OBS-1:0][9:0]    obs_l, obs_r;
  logic [NUM_OBS-1:0][8:0]    obs_t, obs_b;

  bullet_pool_if #(.NUM_BULLETS(5)) bus0 ();
  bullet_pool_if #(.NUM_BULLETS(5)) bus1 ();

  assign bus0.keycode = keycode;  assign bus1.keycode = keycode;
  assign bus0.TankX = tank_x;     assign bus1.TankX = tank_x;
  assign bus0.TankY = tank_y;     assign bus1.TankY = tank_y;
  assign bus0.TankDir = tank_dir; assign bus1.TankDir = tank_dir;
  assign bus0.shoot_en = shoot_en;   assign bus1.shoot_en = shoot_en;
  assign bus0.TankDead = tank_dead;  assign bus1.TankDead = tank_dead;
  assign bus0.obs_left = obs_l;   assign bus1.obs_left = obs_l;
  assign bus0.obs_right = obs_r;  assign bus1.obs_right = obs_r;
  assign bus0.obs_top = obs_t;    assign bus1.obs_top = obs_t;
  assign bus0.obs_bottom = obs_b; assign bus1.obs_bottom = obs_b;

  bullet_pool #(.COOLDOWN(8)) dut0 (.frame_clk(frame_clk), .Reset(Reset), .bus(bus0));
  bullet_pool #(.COOLDOWN(1)) dut1 (.frame_clk(frame_clk), .Reset(Reset), .bus(bus1));

  int tests = 0;
  int fails = 0;
  exp_t q0[$];
  exp_t q1[$];

  // Reference state: one row per pool instance.
  int m_act [2][5];
  int m_x   [2][5];
  int m_y   [2][5];
  int m_dir [2][5];
  int m_age [2][5];
  int m_cd  [2];
  int m_prev[2];
  int cd_len[2] = '{8, 1};
  int dx[4] = '{0, 0, -1, 1};
  int dy[4] = '{-1, 1, 0, 0};

  task automatic check(input int n, input int s, input string nm, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s inst%0d slot%0d: got %0d, expected %0d (t=%0t)", nm, n, s, got, want, $time);
    end
  endtask

  task automatic model_step(input int n);
    int   fire_now, free_slot, spawn, d, nx, ny, die;
    exp_t e;
    fire_now = 0;
    for (int b = 0; b < 4; b++) if (keycode[8*b +: 8] == 8'h2C) fire_now = 1;
    spawn = 0;
    if (Reset) begin
      for (int i = 0; i < 5; i++) begin
        m_act[n][i] = 0; m_x[n][i] = 0; m_y[n][i] = 0; m_dir[n][i] = 0; m_age[n][i] = 0;
      end
      m_cd[n] = 0;
      m_prev[n] = 0;
    end else begin
      free_slot = -1;
      for (int i = 0; i < 5; i++) if (m_act[n][i] == 0 && free_slot < 0) free_slot = i;
      spawn = (fire_now == 1 && m_prev[n] == 0 && shoot_en && !tank_dead &&
               m_cd[n] == 0 && free_slot >= 0) ? 1 : 0;
      for (int i = 0; i < 5; i++) begin
        if (spawn == 1 && i == free_slot) begin
          d = int'(tank_dir);
          m_act[n][i] = 1; m_age[n][i] = 0; m_dir[n][i] = d;
          m_x[n][i] = (int'(tank_x) + 20 * dx[d]) & 1023;
          m_y[n][i] = (int'(tank_y) + 20 * dy[d]) & 1023;
        end else if (m_act[n][i] == 1) begin
          d  = m_dir[n][i];
          nx = m_x[n][i] + 4 * dx[d];
          ny = m_y[n][i] + 4 * dy[d];
          die = (m_age[n][i] == 15 || nx < 2 || nx > 637 || ny < 18 || ny > 477) ? 1 : 0;
          for (int k = 0; k < NUM_OBS; k++)
            if (nx - 2 < int'(obs_r[k]) && nx + 2 > int'(obs_l[k]) &&
                ny - 2 < int'(obs_b[k]) && ny + 2 > int'(obs_t[k])) die = 1;
          if (die == 1) m_act[n][i] = 0;
          else begin
            m_x[n][i] = nx; m_y[n][i] = ny; m_age[n][i] = m_age[n][i] + 1;
          end
        end
      end
      m_cd[n]   = (spawn == 1) ? cd_len[n] - 1 : ((m_cd[n] > 0) ? m_cd[n] - 1 : 0);
      m_prev[n] = fire_now;
    end
    e.pulse = spawn[0];
    for (int i = 0; i < 5; i++) begin
      e.mask[i] = m_act[n][i][0];
      e.x[i]    = 10'(m_x[n][i]);
      e.y[i]    = 10'(m_y[n][i]);
      e.dir[i]  = 3'(m_dir[n][i]);
      e.age[i]  = 4'(m_age[n][i]);
    end
    if (n == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic compare(input int n, input exp_t g, input exp_t e);
    check(n, -1, "active_mask", int'(g.mask), int'(e.mask));
    check(n, -1, "fire_pulse", int'(g.pulse), int'(e.pulse));
    for (int i = 0; i < 5; i++) begin
      check(n, i, "BulletX", int'(g.x[i]), int'(e.x[i]));
      check(n, i, "BulletY", int'(g.y[i]), int'(e.y[i]));
      if (e.mask[i]) begin
        check(n, i, "BulletDir", int'(g.dir[i]), int'(e.dir[i]));
        check(n, i, "BulletAge", int'(g.age[i]), int'(e.age[i]));
      end
    end
  endtask

  // Monitor: each frame edge, compare what the pools present against the queued prediction.
  initial begin
    exp_t g;
    forever begin
      @(posedge frame_clk);
      #1;
      if (q0.size() > 0) begin
        g = {bus0.Is_bullet_active, bus0.fire_pulse, bus0.BulletX, bus0.BulletY,
             bus0.BulletDir, bus0.BulletAge};
        compare(0, g, q0.pop_front());
      end
      if (q1.size() > 0) begin
        g = {bus1.Is_bullet_active, bus1.fire_pulse, bus1.BulletX, bus1.BulletY,
             bus1.BulletDir, bus1.BulletAge};
        compare(1, g, q1.pop_front());
      end
    end
  end

  task automatic tick();
    model_step(0);
    model_step(1);
    @(negedge frame_clk);
  endtask

  task automatic frames(input int k);
    repeat (k) tick();
  endtask

  task automatic press(input logic [31:0] kc);
    keycode = kc;
    tick();
    keycode = 32'h0;
    tick();
  endtask

  task automatic aim(input int xx, input int yy, input int dd);
    tank_x = 10'(xx); tank_y = 10'(yy); tank_dir = 3'(dd);
  endtask

  initial begin
    int pos;
    Reset = 1'b1; keycode = 32'h0; shoot_en = 1'b1; tank_dead = 1'b0;
    aim(100, 200, 3);
    obs_l = '0; obs_r = '0; obs_t = '0; obs_b = '0;
    frames(2);
    Reset = 1'b0;
    frames(1);

    // Single press, then let the bullet fly to its age limit.
    press(32'h0000_002C);
    frames(20);

    // Held key fires once; fast toggling is throttled by cooldown.
    keycode = 32'h2C00_0000;
    frames(30);
    keycode = 32'h0;
    tick();
    for (int k = 0; k < 15; k++) press(32'h002C_0000);
    frames(20);

    // Dead tank or shoot_en low blocks firing.
    tank_dead = 1'b1; press(32'h2C);
    tank_dead = 1'b0; shoot_en = 1'b0; press(32'h2C);
    shoot_en = 1'b1;
    frames(10);

    // Upward bullet near the top bound.
    aim(300, 40, 0);
    press(32'h2C);
    frames(4);

    // Obstacle in the path of a rightward bullet.
    obs_l[0] = 10'd150; obs_r[0] = 10'd170; obs_t[0] = 9'd190; obs_b[0] = 9'd210;
    aim(100, 200, 3);
    press(32'h2C00);
    frames(12);
    obs_l = '0; obs_r = '0; obs_t = '0; obs_b = '0;
    frames(20);

    // Fill all slots (slot2 short-lived), fire as slot2 expires, then again.
    for (int k = 0; k < 5; k++) begin
      if (k == 2) aim(300, 60, 0);
      else        aim(100, 200, 3);
      press(32'h2C);
    end
    press(32'h2C);
    keycode = 32'h2C;
    tick();
    keycode = 32'h0;
    frames(3);

    // Reset mid-flight.
    Reset = 1'b1; tick();
    Reset = 1'b0; frames(2);

    // Randomized phase with a few fixed obstacles.
    for (int k = 0; k < 4; k++) begin
      obs_l[k] = 10'($urandom_range(50, 550));
      obs_r[k] = obs_l[k] + 10'($urandom_range(5, 40));
      obs_t[k] = 9'($urandom_range(30, 400));
      obs_b[k] = obs_t[k] + 9'($urandom_range(5, 40));
    end
    for (int f = 0; f < 300; f++) begin
      aim($urandom_range(30, 600), $urandom_range(40, 460), $urandom_range(0, 3));
      shoot_en  = ($urandom_range(0, 9) != 0);
      tank_dead = ($urandom_range(0, 14) == 0);
      Reset     = ($urandom_range(0, 59) == 0);
      keycode   = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        pos = $urandom_range(0, 3);
        keycode[8*pos +: 8] = 8'h2C;
      end
      tick();
    end
    Reset = 1'b0;
    keycode = 32'h0;
    frames(2);

    @(negedge frame_clk);
    check(0, -1, "scoreboard_drain", q0.size(), 0);
    check(1, -1, "scoreboard_drain", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
